// File: rtl/axi4_frame_writer.sv
// axi4_frame_writer: stream-to-memory AXI4 burst write master.
// Drains a FWFT FIFO into a ring of NUM_FRAMES frame buffers using INCR
// bursts of up to BURST_LEN beats, one burst outstanding at a time.
// The last burst of a frame is shortened to the remaining beats.
// Optional build macro: BRESP_CHECK_EN. When defined, a non-OKAY write
// response sets a sticky err flag. When undefined, err is tied low.
module axi4_frame_writer #(
  parameter int          AXI_ADDR_WIDTH  = 32,
  parameter int          AXI_DATA_WIDTH  = 64,
  parameter int          BURST_LEN       = 64,
  parameter int          FRAME_BYTES     = 153600,
  parameter int          NUM_FRAMES      = 3,
  parameter logic [31:0] FRAME_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] FRAME_STRIDE    = 32'h0004_0000,
  parameter int          LEVEL_WIDTH     = 10
) (
  input  logic                        clk_100Mhz,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sof,
  input  logic [AXI_DATA_WIDTH-1:0]   fifo_dout,
  input  logic                        fifo_empty,
  input  logic [LEVEL_WIDTH-1:0]      fifo_level,
  output logic                        fifo_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic                        frame_done,
  output logic [3:0]                  wr_buf_idx,
  output logic [3:0]                  last_buf_idx,
  output logic                        busy,
  output logic                        err
);

  localparam int BYTES       = AXI_DATA_WIDTH / 8;
  localparam int FRAME_BEATS = FRAME_BYTES / BYTES;
  localparam int OFF_W       = $clog2(FRAME_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                    state_q, state_d;
  logic [OFF_W-1:0]          beat_off_q, beat_off_d;
  logic [3:0]                wr_buf_q, wr_buf_d;
  logic [3:0]                last_buf_q, last_buf_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]                awlen_q, awlen_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic                      sof_pend_q, sof_pend_d;
  logic                      frame_done_q, frame_done_d;

  logic [31:0]               beats_left;
  logic [31:0]               burst_beats;
  logic [31:0]               off_sum;
  logic                      level_ok;
  logic                      frame_end;
  logic [AXI_ADDR_WIDTH-1:0] addr_calc;
  logic                      w_valid;
  logic                      w_hs;
  logic                      b_hs;

  // Burst sizing and start address derived from the current frame offset.
  assign beats_left  = FRAME_BEATS - 32'(beat_off_q);
  assign burst_beats = (beats_left < 32'(BURST_LEN)) ? beats_left : 32'(BURST_LEN);
  assign level_ok    = (32'(fifo_level) >= burst_beats);
  assign addr_calc   = AXI_ADDR_WIDTH'(FRAME_BASE_ADDR)
                     + AXI_ADDR_WIDTH'(wr_buf_q) * AXI_ADDR_WIDTH'(FRAME_STRIDE)
                     + AXI_ADDR_WIDTH'(beat_off_q) * AXI_ADDR_WIDTH'(BYTES);
  assign off_sum     = 32'(beat_off_q) + 32'(awlen_q) + 32'd1;
  assign frame_end   = (off_sum == 32'(FRAME_BEATS));

  assign w_valid = (state_q == DATA) && !fifo_empty;
  assign w_hs    = w_valid && WREADY;
  assign b_hs    = (state_q == RESP) && BVALID;

  assign AWADDR       = awaddr_q;
  assign AWLEN        = awlen_q;
  assign AWSIZE       = 3'($clog2(BYTES));
  assign AWBURST      = 2'b01;
  assign AWVALID      = (state_q == ADDR);
  assign WDATA        = fifo_dout;
  assign WSTRB        = '1;
  assign WVALID       = w_valid;
  assign WLAST        = w_valid && (beat_cnt_q == awlen_q);
  assign fifo_rd_en   = w_hs;
  assign BREADY       = (state_q == RESP);
  assign frame_done   = frame_done_q;
  assign wr_buf_idx   = wr_buf_q;
  assign last_buf_idx = last_buf_q;
  assign busy         = (state_q != IDLE);

  // Next-state logic: burst sequencing, frame offset and buffer ring advance.
  always_comb begin
    state_d      = state_q;
    beat_off_d   = beat_off_q;
    wr_buf_d     = wr_buf_q;
    last_buf_d   = last_buf_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    beat_cnt_d   = beat_cnt_q;
    sof_pend_d   = sof_pend_q;
    frame_done_d = 1'b0;

    // A frame restart seen mid-burst is deferred until the burst retires.
    if (sof && (state_q != IDLE)) sof_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sof) begin
          beat_off_d = '0;
        end else if (enable && level_ok) begin
          state_d    = ADDR;
          awaddr_d   = addr_calc;
          awlen_d    = 8'(burst_beats - 32'd1);
          beat_cnt_d = 8'd0;
        end
      end
      ADDR: begin
        if (AWREADY) state_d = DATA;
      end
      DATA: begin
        if (w_hs) begin
          if (beat_cnt_q == awlen_q) state_d = RESP;
          else beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (BVALID) begin
          state_d    = IDLE;
          sof_pend_d = 1'b0;
          if (frame_end) begin
            frame_done_d = 1'b1;
            last_buf_d   = wr_buf_q;
            wr_buf_d     = (wr_buf_q == 4'(NUM_FRAMES - 1)) ? 4'd0 : wr_buf_q + 4'd1;
          end
          if (frame_end || sof_pend_q || sof) beat_off_d = '0;
          else beat_off_d = OFF_W'(off_sum);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_100Mhz or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_off_q   <= '0;
      wr_buf_q     <= 4'd0;
      last_buf_q   <= 4'(NUM_FRAMES - 1);
      awaddr_q     <= AXI_ADDR_WIDTH'(FRAME_BASE_ADDR);
      awlen_q      <= 8'd0;
      beat_cnt_q   <= 8'd0;
      sof_pend_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_off_q   <= beat_off_d;
      wr_buf_q     <= wr_buf_d;
      last_buf_q   <= last_buf_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      beat_cnt_q   <= beat_cnt_d;
      sof_pend_q   <= sof_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BRESP_CHECK_EN
  logic err_q, err_d;

  // Any non-OKAY response on a B handshake latches err until reset.
  always_comb begin
    err_d = err_q;
    if (b_hs && (BRESP != 2'b00)) err_d = 1'b1;
  end

  // Sticky error flag register.
  always_ff @(posedge clk_100Mhz or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^{BRESP, b_hs};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Testbench for axi4_frame_writer: FIFO model, AXI slave responder and
// scoreboards for AW bursts, W data order and frame completions.
module tb_axi4_frame_writer;

  localparam int          DW     = 64;
  localparam int          BL     = 64;
  localparam int          FB     = 1000;   // 125 beats: bursts of 64 + 61
  localparam int          NF     = 3;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] STRIDE = 32'h0004_0000;
`ifdef BRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk, rst, enable, sof;
  logic [63:0]   fifo_dout;
  logic          fifo_empty, fifo_rd_en;
  logic [9:0]    fifo_level;
  logic [31:0]   AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID, AWREADY;
  logic [63:0]   WDATA;
  logic [7:0]    WSTRB;
  logic          WLAST, WVALID, WREADY;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY;
  logic          frame_done, busy, err;
  logic [3:0]    wr_buf_idx, last_buf_idx;

  axi4_frame_writer #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL), .FRAME_BYTES(FB),
    .NUM_FRAMES(NF), .FRAME_BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE), .LEVEL_WIDTH(10)
  ) dut (
    .clk_100Mhz(clk), .rst(rst), .enable(enable), .sof(sof),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_rd_en(fifo_rd_en),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .frame_done(frame_done), .wr_buf_idx(wr_buf_idx), .last_buf_idx(last_buf_idx),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [3:0] last; logic [3:0] wr; } fd_t;

  aw_t         aw_q[$];
  fd_t         fd_q[$];
  logic [63:0] w_q[$];      // expected W data order
  logic [63:0] fifo_q[$];   // FIFO contents (stimulus)

  int n_cmp = 0;
  int n_mis = 0;
  int aw_hs = 0;
  int b_cnt = 0;
  int bad_b = -1;
  int seq   = 0;
  bit feed_en    = 1'b0;
  bit stall_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_burst(input int b, input int off);
    aw_t e;
    int  left;
    left   = (FB / 8) - off;
    e.addr = BASE + 32'(b) * STRIDE + 32'(off * 8);
    e.len  = 8'(((left < BL) ? left : BL) - 1);
    aw_q.push_back(e);
  endtask

  task automatic exp_fd(input int last, input int wr);
    fd_t f;
    f.last = 4'(last);
    f.wr   = 4'(wr);
    fd_q.push_back(f);
  endtask

  task automatic exp_frame(input int b);
    exp_burst(b, 0);
    exp_burst(b, 64);
    exp_fd(b, (b + 1) % NF);
  endtask

  // Monitor (negedge) and slave/FIFO driver (posedge + 1).
  initial begin : mon_drv
    int  beat_i, cur_len, aw_wait;
    bit  pop;
    aw_t e;
    fd_t f;
    beat_i = 0; cur_len = 0; aw_wait = 0; pop = 1'b0;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    fifo_empty = 1'b1; fifo_dout = '0; fifo_level = '0;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      if (!rst) begin
        beat_i = 0; aw_wait = 0;
      end else begin
        if (AWVALID && AWREADY) begin
          if (aw_q.size() == 0) check("aw_unexpected", {32'd0, AWADDR}, 64'hFFFF_FFFF);
          else begin
            e = aw_q.pop_front();
            check("awaddr", AWADDR, e.addr);
            check("awlen", AWLEN, e.len);
            cur_len = int'(e.len);
          end
          beat_i = 0; aw_wait = 0; aw_hs++;
        end else if (AWVALID) begin
          if (aw_q.size() != 0) begin
            check("awaddr_hold", AWADDR, aw_q[0].addr);
            check("awlen_hold", AWLEN, aw_q[0].len);
          end
          aw_wait++;
        end else aw_wait = 0;
        if (fifo_empty && WVALID) check("wvalid_when_empty", WVALID, 0);
        if (WVALID && WREADY) begin
          check("fifo_rd_en", fifo_rd_en, 1);
          if (w_q.size() == 0) check("w_unexpected", WDATA, 64'hX);
          else check("wdata", WDATA, w_q.pop_front());
          check("wlast", WLAST, (beat_i == cur_len) ? 1 : 0);
          beat_i++;
          pop = 1'b1;
        end else if (fifo_rd_en) check("rd_en_spurious", fifo_rd_en, 0);
        if (BVALID && BREADY) begin
          check("beats_per_burst", 64'(beat_i), 64'(cur_len + 1));
          b_cnt++;
        end
        if (frame_done) begin
          if (fd_q.size() == 0) check("fd_unexpected", frame_done, 0);
          else begin
            f = fd_q.pop_front();
            check("last_buf_idx", last_buf_idx, f.last);
            check("wr_buf_idx", wr_buf_idx, f.wr);
          end
        end
      end
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      while (feed_en && fifo_q.size() < 90) begin
        fifo_q.push_back({32'(seq), ~32'(seq)});
        w_q.push_back({32'(seq), ~32'(seq)});
        seq++;
      end
      WREADY  = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      BVALID  = stall_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
      AWREADY = stall_mode ? (AWVALID && aw_wait >= 5) : 1'b1;
      BRESP   = (b_cnt == bad_b) ? 2'b10 : 2'b00;
      fifo_empty = (fifo_q.size() == 0) || (stall_mode && $urandom_range(0, 4) == 0);
      fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
      fifo_level = 10'(fifo_q.size());
    end
  end

  task automatic wait_drain(input string tag, input int budget, input int sof_aw);
    int cyc = 0;
    int dly = 0;
    bit sof_done = 1'b0;
    bit done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (aw_q.size() == 0) enable = 1'b0;
      if (sof_aw >= 0 && !sof_done && aw_hs >= sof_aw) begin
        dly++;
        if (dly == 5) sof = 1'b1;
        else if (dly == 6) begin sof = 1'b0; sof_done = 1'b1; end
      end
      done = (aw_q.size() == 0) && (fd_q.size() == 0) && !busy && !sof;
    end
    enable = 1'b0;
    sof    = 1'b0;
    check({tag, "_drained"}, done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, AWVALID, 0);
    check({tag, "_wvalid"}, WVALID, 0);
    check({tag, "_bready"}, BREADY, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wr_buf"}, wr_buf_idx, 0);
    check({tag, "_last_buf"}, last_buf_idx, NF - 1);
    check({tag, "_awaddr"}, AWADDR, BASE);
  endtask

  initial begin : main
    rst = 1'b1; enable = 1'b0; sof = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("awsize", AWSIZE, 3);
    check("awburst", AWBURST, 1);
    check("wstrb", WSTRB, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    feed_en = 1'b1;

    // Four frames around the ring, second B response flagged as SLVERR.
    for (int f = 0; f < 4; f++) exp_frame(f % NF);
    bad_b = 1;
    enable = 1'b1;
    wait_drain("ring", 4000, -1);
    check("err_after_slverr", err, EXP_ERR);
    check("wr_buf_after_ring", wr_buf_idx, 1);
    check("last_buf_after_ring", last_buf_idx, 0);

    // Random W/B/FIFO stalls with AWREADY delayed five cycles.
    stall_mode = 1'b1;
    exp_frame(1);
    enable = 1'b1;
    wait_drain("stall", 6000, -1);
    stall_mode = 1'b0;

    // sof during DATA of the third burst restarts buffer 0 at offset 0.
    exp_burst(2, 0);
    exp_burst(2, 64);
    exp_fd(2, 0);
    exp_burst(0, 0);
    exp_burst(0, 0);
    exp_burst(0, 64);
    exp_fd(0, 1);
    enable = 1'b1;
    wait_drain("sof", 4000, aw_hs + 3);
    check("err_sticky", err, EXP_ERR);

    // Reset asserted mid-DATA.
    exp_burst(1, 0);
    enable = 1'b1;
    for (int i = 0; i < 500 && aw_q.size() != 0; i++) @(negedge clk);
    enable = 1'b0;
    check("midrst_aw_issued", 64'(aw_q.size()), 0);
    repeat (10) @(negedge clk);
    check("midrst_in_data", WVALID, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_frame(0);
    enable = 1'b1;
    wait_drain("after_rst", 3000, -1);
    check("wr_buf_after_rst", wr_buf_idx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
